// File: rtl/uart_pkg.sv
// Shared definitions for the UART block: arbiter state encoding, default word width, clog2 helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    // Default transmission word width [bit]
    localparam int C_UART_DATA_WIDTH_DEF = 8;

    // Tx arbiter sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SEND   = 2'b01,
        ST_WAITHI = 2'b10,
        ST_WAITLO = 2'b11
    } sm_state_t;

    // Ceiling log2, never below 1 so single-entry indices still get a bit
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rr_select.sv
// Rotating-priority selector: first set request at or above ptr, wrapping past the top.
// Latency: combinational.
// Backpressure: none; the caller decides whether to act on the winner.
//
// Ports:
//   req       request vector, one bit per requester
//   ptr       index with highest priority this cycle (must be < C_NUM_REQ)
//   win       winning index (0 when nothing is requested)
//   any_valid high when at least one request bit is set
module uart_rr_select
    import uart_pkg::*;
#(
    parameter int C_NUM_REQ = 4,
    parameter int C_IDX_W   = clog2(C_NUM_REQ)
) (
    input  logic [C_NUM_REQ-1:0] req,
    input  logic [C_IDX_W-1:0]   ptr,
    output logic [C_IDX_W-1:0]   win,
    output logic                 any_valid
);

    logic [C_IDX_W-1:0] idx;

    always_comb begin
        win       = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int i = 0; i < C_NUM_REQ; i++) begin
            idx = C_IDX_W'((int'(ptr) + i) % C_NUM_REQ);
            if (!any_valid && req[idx]) begin
                any_valid = 1'b1;
                win       = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART_Tx among C_NUM_REQ byte sources with round-robin grants and busy-handshake tracking.
// Latency: reqValid sampled at edge k -> reqAck and txSend high in the cycle after edge k.
// Backpressure: grants only when enabled, idle and txBusy low; losers keep their level and wait.
//
// Ports:
//   clk, rstb         clock, synchronous active-low reset
//   enable            allow new grants (in-flight byte always completes)
//   reqValid/reqData  per-requester pending level and byte (requester i at bits [i*W +: W])
//   reqAck            one-cycle accept pulse for the granted requester
//   txBusy/txErrIn    status from UART_Tx
//   txSend/txData     send pulse and byte to UART_Tx; txData held until the next grant
//   grantId           last granted requester
//   active            grant until Tx busy falls
//   err/errClr        sticky error (busy timeout or Tx error) and its clear
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int C_UART_DATA_WIDTH = C_UART_DATA_WIDTH_DEF,
    parameter  int C_NUM_REQ         = 4,
    parameter  int C_BUSY_TIMEOUT    = 64,
    localparam int C_IDX_W           = clog2(C_NUM_REQ),
    localparam int C_CNT_W           = clog2(C_BUSY_TIMEOUT)
) (
    input  logic                                 clk,
    input  logic                                 rstb,
    input  logic                                 enable,
    input  logic [C_NUM_REQ-1:0]                 reqValid,
    input  logic [C_NUM_REQ*C_UART_DATA_WIDTH-1:0] reqData,
    output logic [C_NUM_REQ-1:0]                 reqAck,
    input  logic                                 txBusy,
    input  logic                                 txErrIn,
    output logic                                 txSend,
    output logic [C_UART_DATA_WIDTH-1:0]         txData,
    output logic [C_IDX_W-1:0]                   grantId,
    output logic                                 active,
    output logic                                 err,
    input  logic                                 errClr
);

    // The counter starts at 0 on entry to WAITHI, one cycle after the send
    // cycle, so reaching TIMEOUT-2 there flags err exactly C_BUSY_TIMEOUT
    // cycles after txSend was high.
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(C_BUSY_TIMEOUT - 2);
    localparam logic [C_IDX_W-1:0] C_IDX_LAST = C_IDX_W'(C_NUM_REQ - 1);

    sm_state_t              state;
    logic [C_IDX_W-1:0]     ptr;
    logic [C_IDX_W-1:0]     win;
    logic [C_IDX_W-1:0]     ptr_next;
    logic                   any_valid;
    logic [C_CNT_W-1:0]     cnt;
    logic [C_UART_DATA_WIDTH-1:0] win_dat;

    uart_rr_select #(
        .C_NUM_REQ (C_NUM_REQ),
        .C_IDX_W   (C_IDX_W)
    ) u_rr_select (
        .req       (reqValid),
        .ptr       (ptr),
        .win       (win),
        .any_valid (any_valid)
    );

    assign ptr_next = (win == C_IDX_LAST) ? '0 : win + C_IDX_W'(1);
    assign win_dat  = C_UART_DATA_WIDTH'(reqData >> (int'(win) * C_UART_DATA_WIDTH));

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state   <= ST_IDLE;
            reqAck  <= '0;
            txSend  <= 1'b0;
            txData  <= '0;
            grantId <= '0;
            active  <= 1'b0;
            err     <= 1'b0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            reqAck <= '0;
            txSend <= 1'b0;

            // Clear first so any set below in the same cycle wins
            if (errClr) begin
                err <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    // txBusy gate also blocks grants while a transfer started
                    // before a reset is still draining
                    if (enable && !txBusy && any_valid) begin
                        txData       <= win_dat;
                        reqAck[win]  <= 1'b1;
                        txSend       <= 1'b1;
                        grantId      <= win;
                        ptr          <= ptr_next;
                        active       <= 1'b1;
                        state        <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    cnt   <= '0;
                    state <= ST_WAITHI;
                end
                ST_WAITHI: begin
                    if (txBusy) begin
                        state <= ST_WAITLO;
                    end else if (cnt == C_CNT_LAST) begin
                        err    <= 1'b1;
                        active <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        cnt <= cnt + C_CNT_W'(1);
                    end
                end
                ST_WAITLO: begin
                    if (txErrIn) begin
                        err <= 1'b1;
                    end
                    if (!txBusy) begin
                        active <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural UART_Tx busy model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           rstb;
    logic           enable;
    logic [N-1:0]   reqValid;
    logic [N*W-1:0] reqData;
    logic [N-1:0]   reqAck;
    logic           txBusy;
    logic           txErrIn;
    logic           txSend;
    logic [W-1:0]   txData;
    logic [1:0]     grantId;
    logic           active;
    logic           err;
    logic           errClr;

    uart_tx_arbiter #(
        .C_UART_DATA_WIDTH (W),
        .C_NUM_REQ         (N),
        .C_BUSY_TIMEOUT    (TMO)
    ) dut (
        .clk      (clk),
        .rstb     (rstb),
        .enable   (enable),
        .reqValid (reqValid),
        .reqData  (reqData),
        .reqAck   (reqAck),
        .txBusy   (txBusy),
        .txErrIn  (txErrIn),
        .txSend   (txSend),
        .txData   (txData),
        .grantId  (grantId),
        .active   (active),
        .err      (err),
        .errClr   (errClr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int m_ptr  = 0;
    int cfg_dly  = 2;
    int cfg_hold = 10;
    bit tx_never = 1'b0;
    int dly_cnt  = 0;
    int hold_cnt = 0;
    int fall_cyc = 0;
    int send_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; then the Tx model reacts to what the arbiter just drove
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (txBusy) begin
            hold_cnt--;
            if (hold_cnt <= 0) begin
                txBusy   = 1'b0;
                fall_cyc = cyc;
            end
        end else if (dly_cnt > 0) begin
            dly_cnt--;
            if (dly_cnt == 0) begin
                txBusy   = 1'b1;
                hold_cnt = cfg_hold;
            end
        end
        if (txSend) begin
            send_cyc = cyc;
            if (!tx_never) dly_cnt = cfg_dly;
        end
    endtask

    // Round-robin reference: first pending requester from pointer upward, wrapping
    function automatic int rr_winner(input logic [N-1:0] m, input int p);
        int mi;
        mi = int'(m);
        for (int i = 0; i < N; i++) begin
            if (((mi >> ((p + i) % N)) & 1) != 0) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic reset_checks(input string tag);
        chk({tag, "_ack"},    32'(reqAck),  0);
        chk({tag, "_send"},   32'(txSend),  0);
        chk({tag, "_data"},   32'(txData),  0);
        chk({tag, "_gid"},    32'(grantId), 0);
        chk({tag, "_active"}, 32'(active),  0);
        chk({tag, "_err"},    32'(err),     0);
    endtask

    task automatic do_reset(input string tag);
        rstb = 1'b0;
        tick();
        tick();
        reset_checks(tag);
        rstb  = 1'b1;
        m_ptr = 0;
    endtask

    // Present a request set, expect the grant on the very next edge
    task automatic grant(input logic [N-1:0] m, input logic [N*W-1:0] d, input bit keep, input string tag);
        int           w;
        logic [N-1:0] exp_ack;
        reqValid = m;
        reqData  = d;
        w        = rr_winner(m, m_ptr);
        exp_ack  = N'(1) << w;
        tick();
        chk({tag, "_ack"},    32'(reqAck),  32'(exp_ack));
        chk({tag, "_send"},   32'(txSend),  1);
        chk({tag, "_data"},   32'(txData),  32'(W'(d >> (w * W))));
        chk({tag, "_gid"},    32'(grantId), w);
        chk({tag, "_active"}, 32'(active),  1);
        m_ptr = (w + 1) % N;
        if (!keep) reqValid = reqValid & ~exp_ack;
        tick();
        chk({tag, "_ack_pulse"},  32'(reqAck), 0);
        chk({tag, "_send_pulse"}, 32'(txSend), 0);
    endtask

    task automatic wait_done(input string tag);
        bit seen_ack;
        bit done;
        seen_ack = 1'b0;
        done     = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            tick();
            if (reqAck != '0) seen_ack = 1'b1;
            if (!active) done = 1'b1;
        end
        chk({tag, "_done"},     32'(done),     1);
        chk({tag, "_fall_lat"}, cyc,           fall_cyc + 1);
        chk({tag, "_no_ack"},   32'(seen_ack), 0);
    endtask

    // Returns once the arbiter is in its wait-for-busy-low phase
    task automatic wait_busy_hi(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (txBusy) found = 1'b1;
            else tick();
        end
        chk({tag, "_busy_hi"}, 32'(found), 1);
        tick();
    endtask

    initial begin
        bit           seen;
        logic [N-1:0] m;
        logic [N*W-1:0] d;

        rstb     = 1'b0;
        enable   = 1'b1;
        reqValid = '0;
        reqData  = '0;
        txBusy   = 1'b0;
        txErrIn  = 1'b0;
        errClr   = 1'b0;

        // 1: single requester
        do_reset("rst0");
        grant(4'b0010, 32'h0000_A500, 1'b0, "t1");
        wait_done("t1");
        chk("t1_data_hold", 32'(txData),  32'hA5);
        chk("t1_gid_hold",  32'(grantId), 1);

        // 2: all four held valid, then req3+req0 with pointer back at 0
        do_reset("rst2");
        for (int k = 0; k < N; k++) begin
            grant(4'hF, 32'h1312_1110, 1'b1, "t2");
            wait_done("t2");
        end
        grant(4'b1001, 32'h3300_0030, 1'b0, "t2b");
        wait_done("t2b");
        grant(4'b1000, 32'h3300_0030, 1'b0, "t2c");
        wait_done("t2c");

        // 3: busy never rises
        tx_never = 1'b1;
        grant(4'b0100, 32'h0077_0000, 1'b0, "t3");
        for (int i = 0; i < 100 && !err; i++) tick();
        chk("t3_err",     32'(err),    1);
        chk("t3_err_lat", cyc,         send_cyc + TMO);
        chk("t3_active",  32'(active), 0);
        tx_never = 1'b0;
        grant(4'b0001, 32'h0000_0042, 1'b0, "t3b");
        wait_done("t3b");
        chk("t3_sticky", 32'(err), 1);
        errClr = 1'b1;
        tick();
        errClr = 1'b0;
        chk("t3_clr", 32'(err), 0);

        // 4: enable dropped while a byte is in flight
        cfg_hold = 8;
        grant(4'b0010, 32'h0000_5500, 1'b0, "t4");
        wait_busy_hi("t4");
        enable   = 1'b0;
        reqValid = 4'b0100;
        reqData  = 32'h0066_0000;
        wait_done("t4");
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (reqAck != '0) seen = 1'b1;
        end
        chk("t4_no_ack_disabled", 32'(seen), 0);
        enable = 1'b1;
        grant(4'b0100, 32'h0066_0000, 1'b0, "t4b");
        wait_done("t4b");

        // 5: reset while Tx still busy; a pending request waits for busy low
        cfg_hold = 10;
        grant(4'b0001, 32'h0000_0011, 1'b0, "t5");
        wait_busy_hi("t5");
        txErrIn = 1'b1;
        tick();
        txErrIn = 1'b0;
        chk("t5_err_pre", 32'(err), 1);
        rstb     = 1'b0;
        reqValid = 4'b0010;
        reqData  = 32'h0000_2200;
        tick();
        reset_checks("t5_rst");
        chk("t5_busy_stale", 32'(txBusy), 1);
        rstb  = 1'b1;
        m_ptr = 0;
        seen  = 1'b0;
        for (int i = 0; i < 50 && txBusy; i++) begin
            tick();
            if (reqAck != '0) seen = 1'b1;
        end
        chk("t5_no_ack_busy", 32'(seen), 0);
        grant(4'b0010, 32'h0000_2200, 1'b0, "t5b");
        wait_done("t5b");

        // 6: Tx error coinciding with clear; clear alone afterwards
        grant(4'b1000, 32'h9900_0000, 1'b0, "t6");
        wait_busy_hi("t6");
        txErrIn = 1'b1;
        errClr  = 1'b1;
        tick();
        chk("t6_set_wins", 32'(err), 1);
        txErrIn = 1'b0;
        tick();
        chk("t6_clr", 32'(err), 0);
        errClr = 1'b0;
        wait_done("t6");

        // Randomised traffic against the round-robin reference
        for (int it = 0; it < 30; it++) begin
            m        = N'($urandom_range(1, (1 << N) - 1));
            d        = $urandom;
            cfg_dly  = $urandom_range(1, 4);
            cfg_hold = $urandom_range(1, 6);
            grant(m, d, 1'($urandom_range(0, 1)), "rnd");
            wait_done("rnd");
        end
        chk("rnd_err", 32'(err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
